// File: rtl/uart_cmd_parser.sv
// Receive-side command parser: assembles opcode/payload frames from the UART byte
// stream and issues one-cycle register-file and ALU requests.
//
// state   | meaning
// IDLE    | waiting for an opcode byte
// WR_ADDR | write frame, expecting address byte
// WR_DATA | write frame, expecting data byte
// RD_ADDR | read frame, expecting address byte
// OP_A    | ALU frame, expecting operand A
// OP_B    | ALU frame, expecting operand B
// OP_FUN  | ALU frame, expecting function code
module uart_cmd_parser #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    output logic                  CMD_ERR,
    output logic                  BUSY
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, OP_FUN
    } state_t;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [DATA_WIDTH-1:0] OPC_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OPC_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OPC_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OPC_FUN = DATA_WIDTH'(8'hDD);

    state_t           state;
    logic [CNT_W-1:0] gap_cnt;
    logic             addr_ok;
    logic             fun_ok;

    // Address and function bytes are rejected if they carry bits beyond their field.
    assign addr_ok = (RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH] == '0);
    assign fun_ok  = (RX_P_DATA[DATA_WIDTH-1:4] == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_FUN    <= '0;
            ALU_EN     <= 1'b0;
            CMD_ERR    <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            RF_WrEn <= 1'b0;
            RF_RdEn <= 1'b0;
            ALU_EN  <= 1'b0;
            CMD_ERR <= 1'b0;
            if (RX_D_VLD) begin
                gap_cnt <= '0;
                case (state)
                    IDLE: begin
                        case (RX_P_DATA)
                            OPC_WR:  begin state <= WR_ADDR; BUSY <= 1'b1; end
                            OPC_RD:  begin state <= RD_ADDR; BUSY <= 1'b1; end
                            OPC_ALU: begin state <= OP_A;    BUSY <= 1'b1; end
                            OPC_FUN: begin state <= OP_FUN;  BUSY <= 1'b1; end
                            default: CMD_ERR <= 1'b1;
                        endcase
                    end
                    WR_ADDR: begin
                        if (addr_ok) begin
                            RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            state      <= WR_DATA;
                        end else begin
                            state   <= IDLE;
                            BUSY    <= 1'b0;
                            CMD_ERR <= 1'b1;
                        end
                    end
                    WR_DATA: begin
                        RF_WrData <= RX_P_DATA;
                        RF_WrEn   <= 1'b1;
                        state     <= IDLE;
                        BUSY      <= 1'b0;
                    end
                    RD_ADDR: begin
                        if (addr_ok) begin
                            RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            RF_RdEn    <= 1'b1;
                        end else begin
                            CMD_ERR <= 1'b1;
                        end
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                    OP_A: begin
                        ALU_A <= RX_P_DATA;
                        state <= OP_B;
                    end
                    OP_B: begin
                        ALU_B <= RX_P_DATA;
                        state <= OP_FUN;
                    end
                    OP_FUN: begin
                        if (fun_ok) begin
                            ALU_FUN <= RX_P_DATA[3:0];
                            ALU_EN  <= 1'b1;
                        end else begin
                            CMD_ERR <= 1'b1;
                        end
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end else if (state != IDLE) begin
                // A byte arriving in the terminal cycle is taken above, so it beats the timeout.
                if (gap_cnt == CNT_LAST) begin
                    state   <= IDLE;
                    BUSY    <= 1'b0;
                    CMD_ERR <= 1'b1;
                    gap_cnt <= '0;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: table of frames with hand-computed results plus
// hand-written sequences for back-to-back, timeout and reset corner cases.
module tb_uart_cmd_parser;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;

    logic [3:0] RF_Address;
    logic [7:0] RF_WrData;
    logic       RF_WrEn, RF_RdEn;
    logic [7:0] ALU_A, ALU_B;
    logic [3:0] ALU_FUN;
    logic       ALU_EN, CMD_ERR, BUSY;

    logic [3:0] t_addr;
    logic [7:0] t_wd, t_a, t_b;
    logic [3:0] t_fun;
    logic       t_wren, t_rden, t_alu_en, t_err, t_busy;

    uart_cmd_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_Address(RF_Address), .RF_WrData(RF_WrData), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .CMD_ERR(CMD_ERR), .BUSY(BUSY)
    );

    uart_cmd_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(8)) dut_to (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_Address(t_addr), .RF_WrData(t_wd), .RF_WrEn(t_wren), .RF_RdEn(t_rden),
        .ALU_A(t_a), .ALU_B(t_b), .ALU_FUN(t_fun), .ALU_EN(t_alu_en),
        .CMD_ERR(t_err), .BUSY(t_busy)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    int n_wr, n_rd, n_alu, n_err, n_busy, n_overlap;
    logic [3:0] cap_addr, cap_fun;
    logic [7:0] cap_wd, cap_a, cap_b;

    always @(negedge CLK) begin
        if (!RST) begin
            if (RF_WrEn) begin n_wr++; cap_addr = RF_Address; cap_wd = RF_WrData; end
            if (RF_RdEn) begin n_rd++; cap_addr = RF_Address; end
            if (ALU_EN) begin n_alu++; cap_a = ALU_A; cap_b = ALU_B; cap_fun = ALU_FUN; end
            if (CMD_ERR) n_err++;
            if (BUSY) n_busy++;
            if (32'(RF_WrEn) + 32'(RF_RdEn) + 32'(ALU_EN) > 1) n_overlap++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = '0;
    endtask

    task automatic clear_mon();
        n_wr = 0; n_rd = 0; n_alu = 0; n_err = 0; n_busy = 0;
    endtask

    typedef struct {
        logic [31:0] bytes;
        int          n;
        int          gap;
        int          e_wr, e_rd, e_alu, e_err, e_busy;
        logic [3:0]  e_addr;
        logic [7:0]  e_wd, e_a, e_b;
        logic [3:0]  e_fun;
    } vec_t;

    vec_t vec[8];

    initial begin
        n_overlap = 0;
        clear_mon();
        // bytes packed MSB-first; DD 03 relies on A/B held from the back-to-back ALU frame
        vec[0] = '{32'hDD03_0000, 2, 1,  0, 0, 1, 0, 1,  4'h0, 8'h00, 8'h12, 8'h34, 4'h3};
        vec[1] = '{32'hAA05_3C00, 3, 16, 1, 0, 0, 0, 32, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0};
        vec[2] = '{32'h5500_0000, 1, 1,  0, 0, 0, 1, 0,  4'h0, 8'h00, 8'h00, 8'h00, 4'h0};
        vec[3] = '{32'hAA15_0000, 2, 1,  0, 0, 0, 1, 1,  4'h0, 8'h00, 8'h00, 8'h00, 4'h0};
        vec[4] = '{32'hCC01_021F, 4, 1,  0, 0, 0, 1, 3,  4'h0, 8'h00, 8'h00, 8'h00, 4'h0};
        vec[5] = '{32'hAA0F_FF00, 3, 1,  1, 0, 0, 0, 2,  4'hF, 8'hFF, 8'h00, 8'h00, 4'h0};
        vec[6] = '{32'hDD10_0000, 2, 1,  0, 0, 0, 1, 1,  4'h0, 8'h00, 8'h00, 8'h00, 4'h0};
        vec[7] = '{32'hBB00_0000, 2, 1,  0, 1, 0, 0, 1,  4'h0, 8'h00, 8'h00, 8'h00, 4'h0};

        repeat (3) tick();
        chk("reset_outputs",
            {RF_Address, RF_WrData, RF_WrEn, RF_RdEn, ALU_A, ALU_B, ALU_FUN, ALU_EN, CMD_ERR, BUSY}, 0);
        RST = 1'b0;
        tick();

        // read then ALU frame with a byte every cycle
        clear_mon();
        send(8'hBB); send(8'h0A); send(8'hCC); send(8'h12); send(8'h34); send(8'h02);
        repeat (3) tick();
        chk("b2b_rd_cnt", n_rd, 1);
        chk("b2b_alu_cnt", n_alu, 1);
        chk("b2b_err_cnt", n_err, 0);
        chk("b2b_busy_cycles", n_busy, 4);
        chk("b2b_rd_addr", cap_addr, 4'hA);
        chk("b2b_alu_ops", {cap_a, cap_b, cap_fun}, {8'h12, 8'h34, 4'h2});

        for (int i = 0; i < 8; i++) begin
            clear_mon();
            for (int j = 0; j < vec[i].n; j++) begin
                send(vec[i].bytes[31-8*j -: 8]);
                if (j < vec[i].n - 1) repeat (vec[i].gap - 1) tick();
            end
            repeat (3) tick();
            chk($sformatf("v%0d_wr_cnt", i), n_wr, vec[i].e_wr);
            chk($sformatf("v%0d_rd_cnt", i), n_rd, vec[i].e_rd);
            chk($sformatf("v%0d_alu_cnt", i), n_alu, vec[i].e_alu);
            chk($sformatf("v%0d_err_cnt", i), n_err, vec[i].e_err);
            chk($sformatf("v%0d_busy_cycles", i), n_busy, vec[i].e_busy);
            if (vec[i].e_wr > 0)
                chk($sformatf("v%0d_wr_fields", i), {cap_addr, cap_wd}, {vec[i].e_addr, vec[i].e_wd});
            if (vec[i].e_rd > 0)
                chk($sformatf("v%0d_rd_addr", i), cap_addr, vec[i].e_addr);
            if (vec[i].e_alu > 0)
                chk($sformatf("v%0d_alu_ops", i), {cap_a, cap_b, cap_fun},
                    {vec[i].e_a, vec[i].e_b, vec[i].e_fun});
        end

        // timeout on the TIMEOUT=8 instance
        RST = 1'b1; tick(); RST = 1'b0; repeat (2) tick();
        send(8'hBB);
        repeat (7) tick();
        chk("to_err_early", t_err, 0);
        chk("to_busy_early", t_busy, 1);
        tick();
        chk("to_err_pulse", t_err, 1);
        chk("to_busy_fall", t_busy, 0);
        tick();
        chk("to_err_single", t_err, 0);

        send(8'hBB);
        repeat (7) tick();
        chk("bnd_busy_hold", {t_busy, t_err}, 2'b10);
        send(8'h04);
        chk("bnd_rden", t_rden, 1);
        chk("bnd_no_err", t_err, 0);
        chk("bnd_addr", t_addr, 4'h4);
        chk("bnd_busy_fall", t_busy, 0);
        repeat (10) tick();

        // reset mid-frame drops the partial frame silently
        clear_mon();
        send(8'hAA); send(8'h03);
        RST = 1'b1;
        tick();
        chk("rst_outputs",
            {RF_Address, RF_WrData, RF_WrEn, RF_RdEn, ALU_A, ALU_B, ALU_FUN, ALU_EN, CMD_ERR, BUSY}, 0);
        RST = 1'b0;
        repeat (3) tick();
        chk("rst_no_strobes", n_wr + n_rd + n_alu + n_err, 0);
        clear_mon();
        send(8'hAA); send(8'h03); send(8'h77);
        repeat (3) tick();
        chk("post_rst_wr_cnt", n_wr, 1);
        chk("post_rst_wr_fields", {cap_addr, cap_wd}, {4'h3, 8'h77});
        chk("post_rst_err_cnt", n_err, 0);

        chk("strobe_overlap", n_overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
